score_board_mp: RTL



---
 rtl/score_board_mp.sv | 116 +++++++++++
 1 files changed

// File: rtl/score_board_mp.sv
`default_nettype none
// ============================================================================
// Module  : score_board_mp
// Brief   : Register-file scoreboard with per-register pending counts, rolling
//           writer tags and youngest-first operand forwarding.
// Revision: 1.0
// ============================================================================
module score_board_mp #(
    parameter int NUM_RD    = 2,
    parameter int NUM_FWD   = 3,
    parameter int TAG_WIDTH = 2,
    parameter int XLEN      = 32,
    parameter int NREG      = 32,
    localparam int AW       = $clog2(NREG)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         alloc_en,
    input  logic [AW-1:0]                alloc_addr,
    output logic                         alloc_ready,
    output logic [TAG_WIDTH-1:0]         alloc_tag,
    input  logic                         ret_en,
    input  logic [AW-1:0]                ret_addr,
    input  logic [TAG_WIDTH-1:0]         ret_tag,
    input  logic [XLEN-1:0]              ret_data,
    input  logic [NUM_FWD-1:0]           fwd_en,
    input  logic [NUM_FWD*AW-1:0]        fwd_addr,
    input  logic [NUM_FWD*TAG_WIDTH-1:0] fwd_tag,
    input  logic [NUM_FWD*XLEN-1:0]      fwd_data,
    input  logic [NUM_RD-1:0]            rd_en,
    input  logic [NUM_RD*AW-1:0]         rd_addr,
    output logic [NUM_RD*XLEN-1:0]       rd_data,
    output logic [NUM_RD-1:0]            rd_valid
);

    logic [XLEN-1:0]      rf_q   [NREG];
    logic [XLEN-1:0]      rf_d   [NREG];
    logic [TAG_WIDTH-1:0] tag_q  [NREG];
    logic [TAG_WIDTH-1:0] tag_d  [NREG];
    logic [TAG_WIDTH-1:0] pend_q [NREG];
    logic [TAG_WIDTH-1:0] pend_d [NREG];

    // Retire order is trusted, so the commit tag never gates the write.
    logic unused_ret_tag;
    assign unused_ret_tag = ^ret_tag;

    // A full pending counter would let a new tag alias an in-flight one.
    assign alloc_ready = !flush && (pend_q[alloc_addr] != '1);
    assign alloc_tag   = tag_q[alloc_addr] + TAG_WIDTH'(1);

    generate
        for (genvar r = 0; r < NREG; r++) begin : g_reg
            if (r == 0) begin : g_zero
                assign rf_d[r]   = '0;
                assign tag_d[r]  = '0;
                assign pend_d[r] = '0;
            end else begin : g_live
                logic w_do_alloc;
                logic w_do_ret;
                assign w_do_alloc = alloc_en && alloc_ready && (alloc_addr == AW'(r));
                assign w_do_ret   = ret_en && (ret_addr == AW'(r));
                assign rf_d[r]    = w_do_ret ? ret_data : rf_q[r];
                assign tag_d[r]   = w_do_alloc ? tag_q[r] + TAG_WIDTH'(1) : tag_q[r];
                assign pend_d[r]  = flush                                   ? '0 :
                                    (w_do_alloc && !w_do_ret)               ? pend_q[r] + TAG_WIDTH'(1) :
                                    (w_do_ret && !w_do_alloc && pend_q[r] != '0) ? pend_q[r] - TAG_WIDTH'(1) :
                                    pend_q[r];
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_q   <= '{default: '0};
            tag_q  <= '{default: '0};
            pend_q <= '{default: '0};
        end else begin
            rf_q   <= rf_d;
            tag_q  <= tag_d;
            pend_q <= pend_d;
        end
    end

    generate
        for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
            logic [AW-1:0]   w_addr;
            logic            w_hit;
            logic [XLEN-1:0] w_fdata;
            logic            w_clean;

            assign w_addr  = rd_addr[p*AW +: AW];
            assign w_clean = (pend_q[w_addr] == '0);

            // Scan oldest to youngest so the youngest matching stage wins.
            always_comb begin
                w_hit   = 1'b0;
                w_fdata = '0;
                for (int i = NUM_FWD - 1; i >= 0; i--) begin
                    if (fwd_en[i] && (fwd_addr[i*AW +: AW] == w_addr) &&
                        (fwd_tag[i*TAG_WIDTH +: TAG_WIDTH] == tag_q[w_addr])) begin
                        w_hit   = 1'b1;
                        w_fdata = fwd_data[i*XLEN +: XLEN];
                    end
                end
            end

            assign rd_valid[p] = rd_en[p] && ((w_addr == '0) || w_clean || w_hit);
            assign rd_data[p*XLEN +: XLEN] = (!rd_en[p] || (w_addr == '0)) ? '0 :
                                             w_clean ? rf_q[w_addr] :
                                             w_hit   ? w_fdata : '0;
        end
    endgenerate

endmodule
`default_nettype wire
